// File: rtl/operand_sequencer.sv
// Two-operand entry sequencer: debounces a pushbutton and walks
// LOAD_A -> LOAD_B -> READY, latching the switch value on each press.
// Ports:
//   clk     - single clock, rising edge
//   reset   - async active-high reset
//   key_n   - raw active-low pushbutton (asynchronous)
//   clear   - sync restart of operand entry, beats a press
//   sw[3:0] - operand value, sampled on capture
//   a, b    - captured operands (registered)
//   valid   - a and b hold a completed pair (registered)
//   stage   - current FSM state code
module operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       clear,
  input  logic [3:0] sw,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       valid,
  output logic [1:0] stage
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] LOAD_A = 2'b00;
  localparam logic [1:0] LOAD_B = 2'b01;
  localparam logic [1:0] READY  = 2'b10;

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_d;
  logic          press;
  logic [CW-1:0] cnt;
  logic [1:0]    state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  // Counter only runs while s2 disagrees with db, so it
  // tops out at LAST and can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db  <= 1'b1;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Press is registered off a delayed copy of db: one-cycle
  // pulse after a 1->0 transition, nothing on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_d  <= 1'b1;
      press <= 1'b0;
    end else begin
      db_d  <= db;
      press <= db_d & ~db;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_A;
      a     <= '0;
      b     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      state <= LOAD_A;
      a     <= '0;
      b     <= '0;
      valid <= 1'b0;
    end else if (press) begin
      unique case (state)
        LOAD_A: begin
          a     <= sw;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b     <= sw;
          valid <= 1'b1;
          state <= READY;
        end
        READY: begin
          a     <= sw;
          valid <= 1'b0;
          state <= LOAD_B;
        end
        default: begin
          state <= LOAD_A;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign stage = state;

endmodule
